ch1_sweep_sequencer: RTL and testbench



---
 rtl/sound_pkg.sv | 31 +++
 rtl/ch1_sweep_sequencer_if.sv | 25 ++
 rtl/frame_sequencer.sv | 41 ++++
 rtl/ch1_sweep_sequencer.sv | 125 ++++++++++++
 tb/tb_ch1_sweep_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound unit channel logic.
package sound_pkg;

    // Channel-1 sweep controller states.
    typedef enum logic [1:0] {
        IDLE,
        TRIG_CHK,
        CALC,
        RECHECK
    } sweep_state_t;

    localparam logic [10:0] FREQ_MAX = 11'd2047;

    // NR10 field positions.
    localparam int unsigned NR10_PERIOD_HI = 6;
    localparam int unsigned NR10_PERIOD_LO = 4;
    localparam int unsigned NR10_DECREASE  = 3;
    localparam int unsigned NR10_SHIFT_HI  = 2;
    localparam int unsigned NR10_SHIFT_LO  = 0;

    // One bit per frame-sequencer step; a set bit fires that tick on the step.
    localparam logic [7:0] LENGTH_STEPS = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS  = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS    = 8'b1000_0000;

    // A programmed period of 0 behaves as 8 for the sweep timer reload.
    function automatic logic [3:0] eff_period(input logic [2:0] period);
        return (period == 3'd0) ? 4'd8 : {1'b0, period};
    endfunction

endpackage

// File: rtl/ch1_sweep_sequencer_if.sv
// Register-side and tick bus of the channel-1 sweep sequencer.
interface ch1_sweep_sequencer_if;
    logic [7:0]  nr10;
    logic [10:0] freq_in;
    logic        trigger;
    logic [10:0] freq_out;
    logic        freq_we;
    logic        channel_enable;
    logic        length_tick;
    logic        sweep_tick;
    logic        env_tick;
    logic        busy;

    // Register file / APU side.
    modport master (
        output nr10, freq_in, trigger,
        input  freq_out, freq_we, channel_enable, length_tick, sweep_tick, env_tick, busy
    );

    // Sequencer side.
    modport slave (
        input  nr10, freq_in, trigger,
        output freq_out, freq_we, channel_enable, length_tick, sweep_tick, env_tick, busy
    );
endinterface

// File: rtl/frame_sequencer.sv
// Divides the system clock to the 512 Hz step rate and decodes tick pulses.
module frame_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned CLK_DIV = 32768
) (
    input  logic clock,
    input  logic reset,
    output logic length_tick,
    output logic sweep_tick,
    output logic env_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [2:0]       step_q;
    logic             terminal;

    assign terminal = (div_q == DIV_LAST);

    // Divider counts 0..CLK_DIV-1; step advances on the terminal count.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            step_q <= 3'd0;
        end else if (terminal) begin
            div_q  <= '0;
            step_q <= step_q + 3'd1;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // Ticks fire during the terminal-count cycle of the current step.
    assign length_tick = terminal && LENGTH_STEPS[step_q];
    assign sweep_tick  = terminal && SWEEP_STEPS[step_q];
    assign env_tick    = terminal && ENV_STEPS[step_q];

endmodule

// File: rtl/ch1_sweep_sequencer.sv
// Channel-1 frame sequencer plus frequency sweep controller.
module ch1_sweep_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned CLK_DIV = 32768
) (
    input  logic                 clock,
    input  logic                 reset,
    ch1_sweep_sequencer_if.slave bus
);

    logic length_tick;
    logic sweep_tick;
    logic env_tick;

    frame_sequencer #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_sequencer (
        .clock       (clock),
        .reset       (reset),
        .length_tick (length_tick),
        .sweep_tick  (sweep_tick),
        .env_tick    (env_tick)
    );

    sweep_state_t state_q;
    logic [3:0]   timer_q;
    logic [10:0]  shadow_q;
    logic         sweep_en_q;
    logic [10:0]  freq_out_q;
    logic         freq_we_q;
    logic         chan_en_q;

    logic [2:0]  period;
    logic [2:0]  shift;
    logic        decrease;
    logic        unused_nr10_msb;
    logic [11:0] shadow_ext;
    logic [11:0] delta;
    logic [11:0] calc;
    logic        overflow;

    assign period          = bus.nr10[NR10_PERIOD_HI:NR10_PERIOD_LO];
    assign shift           = bus.nr10[NR10_SHIFT_HI:NR10_SHIFT_LO];
    assign decrease        = bus.nr10[NR10_DECREASE];
    assign unused_nr10_msb = bus.nr10[7];

    // Single shared adder; always operates on the current shadow register.
    assign shadow_ext = {1'b0, shadow_q};
    assign delta      = shadow_ext >> shift;
    assign calc       = decrease ? (shadow_ext - delta) : (shadow_ext + delta);
    assign overflow   = (calc > {1'b0, FREQ_MAX});

    // Sweep FSM; a trigger pre-empts any in-flight sequence and any same-cycle tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= 4'd0;
            shadow_q   <= 11'd0;
            sweep_en_q <= 1'b0;
            freq_out_q <= 11'd0;
            freq_we_q  <= 1'b0;
            chan_en_q  <= 1'b0;
        end else begin
            freq_we_q <= 1'b0;
            if (bus.trigger) begin
                shadow_q   <= bus.freq_in;
                timer_q    <= eff_period(period);
                sweep_en_q <= (period != 3'd0) || (shift != 3'd0);
                chan_en_q  <= 1'b1;
                state_q    <= (shift != 3'd0) ? TRIG_CHK : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sweep_tick && chan_en_q) begin
                            if (timer_q > 4'd1) begin
                                timer_q <= timer_q - 4'd1;
                            end else begin
                                timer_q <= eff_period(period);
                                if (sweep_en_q && (period != 3'd0)) begin
                                    state_q <= CALC;
                                end
                            end
                        end
                    end
                    TRIG_CHK: begin
                        if (overflow) begin
                            chan_en_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                    CALC: begin
                        if (overflow) begin
                            chan_en_q <= 1'b0;
                            state_q   <= IDLE;
                        end else if (shift != 3'd0) begin
                            shadow_q   <= calc[10:0];
                            freq_out_q <= calc[10:0];
                            freq_we_q  <= 1'b1;
                            state_q    <= RECHECK;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    RECHECK: begin
                        if (overflow) begin
                            chan_en_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.freq_out       = freq_out_q;
    assign bus.freq_we        = freq_we_q;
    assign bus.channel_enable = chan_en_q;
    assign bus.length_tick    = length_tick;
    assign bus.sweep_tick     = sweep_tick;
    assign bus.env_tick       = env_tick;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ch1_sweep_sequencer.sv
// Scoreboard bench for ch1_sweep_sequencer with a fast frame sequencer.
module tb_ch1_sweep_sequencer;

    localparam int unsigned CLK_DIV = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ch1_sweep_sequencer_if bus ();

    ch1_sweep_sequencer #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_count  = 0;
    int cyc       = 0;
    bit mon_on    = 1'b0;
    logic [10:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference cycle count since reset for the tick schedule.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: tick pattern every cycle, and scoreboard pop on each write strobe.
    always @(negedge clock) begin
        if (mon_on && !reset) begin
            int  step;
            bit  term;
            logic [2:0] exp_ticks;
            term = ((cyc % CLK_DIV) == CLK_DIV - 1);
            step = (cyc / CLK_DIV) % 8;
            exp_ticks = {term && (step % 2 == 0),
                         term && (step == 2 || step == 6),
                         term && (step == 7)};
            chk("ticks", {29'd0, bus.length_tick, bus.sweep_tick, bus.env_tick},
                {29'd0, exp_ticks});
            if (bus.freq_we === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_write: got freq_out %0h expected no write",
                             bus.freq_out);
                end else begin
                    chk("freq_out", {21'd0, bus.freq_out}, {21'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_sweep();
        bit found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            tick();
            if (bus.sweep_tick) found = 1'b1;
        end
        if (!found) chk("sweep_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_env();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.env_tick) found = 1'b1;
        end
        if (!found) chk("env_timeout", 32'd0, 32'd1);
    endtask

    // Trigger in an envelope cycle so no sweep tick lands near the trigger.
    task automatic do_trigger(input logic [7:0] nr, input logic [10:0] f);
        wait_env();
        bus.nr10    = nr;
        bus.freq_in = f;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
    endtask

    initial begin
        logic [10:0] seq2 [5];
        logic [7:0]  quiet [2];
        int w0;
        seq2  = '{11'h180, 11'h240, 11'h360, 11'h510, 11'h798};
        quiet = '{8'h00, 8'h08};

        bus.nr10    = 8'h00;
        bus.freq_in = 11'd0;
        bus.trigger = 1'b0;
        tick();
        tick();
        chk("rst_chan_en", {31'd0, bus.channel_enable}, 32'd0);
        chk("rst_freq_we", {31'd0, bus.freq_we}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_freq_out", {21'd0, bus.freq_out}, 32'd0);
        chk("rst_ticks", {29'd0, bus.length_tick, bus.sweep_tick, bus.env_tick}, 32'd0);
        mon_on = 1'b1;
        reset  = 1'b0;

        // Free-running tick schedule.
        repeat (64) tick();

        // Increase by half each period until RECHECK overflows.
        do_trigger(8'h11, 11'h100);
        chk("t2_en_t1", {31'd0, bus.channel_enable}, 32'd1);
        chk("t2_busy_t1", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("t2_en_t2", {31'd0, bus.channel_enable}, 32'd1);
        chk("t2_idle_t2", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(seq2[i]);
            wait_sweep();
            tick();
            tick();
            chk("t2_we", {31'd0, bus.freq_we}, 32'd1);
            chk("t2_en_at_we", {31'd0, bus.channel_enable}, 32'd1);
            tick();
            chk("t2_en_after", {31'd0, bus.channel_enable}, (i == 4) ? 32'd0 : 32'd1);
        end
        w0 = wr_count;
        wait_sweep();
        wait_sweep();
        tick(); tick(); tick();
        chk("t2_no_wr_disabled", wr_count - w0, 32'd0);

        // Trigger-time overflow check.
        do_trigger(8'h01, 11'h700);
        chk("t3_en_t1", {31'd0, bus.channel_enable}, 32'd1);
        chk("t3_busy_t1", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("t3_en_t2", {31'd0, bus.channel_enable}, 32'd0);
        chk("t3_busy_t2", {31'd0, bus.busy}, 32'd0);
        w0 = wr_count;
        wait_sweep();
        wait_sweep();
        tick(); tick(); tick();
        chk("t3_no_wr", wr_count - w0, 32'd0);

        // Decrease sweep.
        do_trigger(8'h1A, 11'h400);
        chk("t4_en", {31'd0, bus.channel_enable}, 32'd1);
        exp_q.push_back(11'h300);
        wait_sweep();
        tick();
        tick();
        chk("t4_we", {31'd0, bus.freq_we}, 32'd1);
        tick();
        chk("t4_en_after", {31'd0, bus.channel_enable}, 32'd1);
        bus.nr10 = 8'h00;

        // Period 3: a write on every third sweep tick.
        do_trigger(8'h31, 11'h100);
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) exp_q.push_back((k == 2) ? 11'h180 : 11'h240);
            wait_sweep();
            w0 = wr_count;
            tick(); tick(); tick();
            chk("t4_period3_writes", wr_count - w0, (k % 3 == 2) ? 32'd1 : 32'd0);
        end
        bus.nr10 = 8'h00;

        // Period 0 with shift 0: enabled, never writes.
        for (int q = 0; q < 2; q++) begin
            do_trigger(quiet[q], 11'h123);
            chk("t5_en", {31'd0, bus.channel_enable}, 32'd1);
            chk("t5_busy", {31'd0, bus.busy}, 32'd0);
            w0 = wr_count;
            wait_sweep();
            wait_sweep();
            wait_sweep();
            tick(); tick(); tick();
            chk("t5_en_held", {31'd0, bus.channel_enable}, 32'd1);
            chk("t5_no_wr", wr_count - w0, 32'd0);
        end

        // Trigger during CALC aborts the write and reloads the shadow.
        do_trigger(8'h11, 11'h100);
        wait_sweep();
        tick();
        chk("t6_busy_calc", {31'd0, bus.busy}, 32'd1);
        bus.freq_in = 11'h050;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        chk("t6_we_suppressed", {31'd0, bus.freq_we}, 32'd0);
        chk("t6_en", {31'd0, bus.channel_enable}, 32'd1);
        chk("t6_busy_trigchk", {31'd0, bus.busy}, 32'd1);
        exp_q.push_back(11'h078);
        wait_sweep();
        tick();
        tick();
        chk("t6_we", {31'd0, bus.freq_we}, 32'd1);
        bus.nr10 = 8'h00;

        // Reset in CALC drops the pending write.
        do_trigger(8'h11, 11'h100);
        wait_sweep();
        tick();
        reset = 1'b1;
        tick();
        chk("t7_we", {31'd0, bus.freq_we}, 32'd0);
        chk("t7_en", {31'd0, bus.channel_enable}, 32'd0);
        chk("t7_busy", {31'd0, bus.busy}, 32'd0);
        chk("t7_freq_out", {21'd0, bus.freq_out}, 32'd0);
        reset = 1'b0;
        w0 = wr_count;
        wait_sweep();
        wait_sweep();
        tick(); tick(); tick();
        chk("t7_no_wr", wr_count - w0, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
